seq_detect_bin: RTL and testbench

//  Parametrised serial-pattern detector. Implemented as a binary-encoded Moore state machine.

---
 rtl/seq_detect_pkg.sv | 38 +++
 rtl/seq_detect_bin_state_reg.sv | 17 +
 rtl/seq_detect_bin.sv | 75 +++++++
 tb/tb_seq_detect_bin.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Items shared across the serial-pattern detector variants: width helper,
// elaboration-time KMP next-state function and the illegal-state recovery target.
package seq_detect_pkg;

    localparam int ILLEGAL_NEXT = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Longest prefix of pat (up to the full pattern) that is a suffix of the
    // k matched bits followed by w; the result is the next automaton state.
    function automatic int next_state(input int k, input int w, input logic [15:0] pat,
                                      input int len, input bit overlap);
        logic [16:0] s;
        int          kk;
        int          best;
        bit          ok;
        best = ILLEGAL_NEXT;
        if (k <= len) begin
            kk = (k == len && !overlap) ? 0 : k;
            s = '0;
            s[0] = (w != 0);
            for (int i = 0; i < kk; i++) s[i+1] = pat[len-kk+i];
            for (int j = 1; j <= len && j <= kk + 1; j++) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++)
                    if (s[j-1-m] != pat[len-1-m]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_bin_state_reg.sv
// Parametrised register with asynchronous active-high reset to DEFAULT.
module state_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) q <= DEFAULT;
        else       q <= d;
    end

endmodule

// File: rtl/seq_detect_bin.sv
// Binary-encoded Moore detector for PATTERN on a serial stream, with input
// enable and a saturating match counter.
module seq_detect_bin
    import seq_detect_pkg::*;
#(
    parameter int          LEN     = 4,
    parameter logic [15:0] PATTERN = 16'b1101,
    parameter bit          OVERLAP = 1'b1,
    parameter int          CNT_W   = 8,
    localparam int         SW      = clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             w,
    input  logic             clear_count,
    output logic [SW-1:0]    State,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam logic [SW-1:0]    S_LEN   = SW'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (LEN < 2 || LEN > 16 || (PATTERN >> LEN) != 16'd0 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("seq_detect_bin: illegal LEN/PATTERN/CNT_W parameters");
    end

    // Constant next-state table indexed by {State, w}; unused encodings map to recovery.
    logic [SW-1:0] ns_tbl [0:2**(SW+1)-1];
    for (genvar k = 0; k < 2**SW; k++) begin : g_k
        for (genvar b = 0; b < 2; b++) begin : g_b
            localparam int NS = next_state(k, b, PATTERN, LEN, OVERLAP);
            assign ns_tbl[2*k+b] = SW'(NS);
        end
    end

    logic [SW-1:0]    state_d;
    logic [CNT_W-1:0] cnt_d;

    // Illegal encodings recover even while en is low.
    always_comb begin
        state_d = State;
        if (en || State > S_LEN) state_d = ns_tbl[{State, w}];
    end

    state_reg #(.WIDTH(SW), .DEFAULT('0)) u_state (
        .clk  (clk),
        .Reset(Reset),
        .d    (state_d),
        .q    (State)
    );

    assign z = (State == S_LEN);

    always_comb begin
        cnt_d = match_count;
        if (clear_count)
            cnt_d = '0;
        else if (en && state_d == S_LEN && !count_sat)
            cnt_d = match_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            match_count <= cnt_d;
            count_sat   <= (cnt_d == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_seq_detect_bin.sv
// Scoreboard bench for seq_detect_bin across four parameter sets sharing one stimulus.
module tb_seq_detect_bin;

    typedef struct packed {
        logic [2:0] st;
        logic       z;
        logic [7:0] cnt;
        logic       sat;
    } obs_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic en = 1'b0;
    logic w = 1'b0;
    logic clear_count = 1'b0;

    logic [2:0] st_def, st_nov, st_c2, st_l5;
    logic       z_def, z_nov, z_c2, z_l5;
    logic [7:0] cnt_def, cnt_nov, cnt_l5;
    logic [1:0] cnt_c2;
    logic       sat_def, sat_nov, sat_c2, sat_l5;

    obs_t o_def, o_nov, o_c2, o_l5;
    assign o_def = {st_def, z_def, cnt_def, sat_def};
    assign o_nov = {st_nov, z_nov, cnt_nov, sat_nov};
    assign o_c2  = {st_c2, z_c2, 6'b0, cnt_c2, sat_c2};
    assign o_l5  = {st_l5, z_l5, cnt_l5, sat_l5};

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    seq_detect_bin d_def (.clk(clk), .Reset(Reset), .en(en), .w(w), .clear_count(clear_count),
                          .State(st_def), .z(z_def), .match_count(cnt_def), .count_sat(sat_def));
    seq_detect_bin #(.OVERLAP(1'b0)) d_nov (.clk(clk), .Reset(Reset), .en(en), .w(w), .clear_count(clear_count),
                          .State(st_nov), .z(z_nov), .match_count(cnt_nov), .count_sat(sat_nov));
    seq_detect_bin #(.CNT_W(2)) d_c2 (.clk(clk), .Reset(Reset), .en(en), .w(w), .clear_count(clear_count),
                          .State(st_c2), .z(z_c2), .match_count(cnt_c2), .count_sat(sat_c2));
    seq_detect_bin #(.LEN(5), .PATTERN(16'b10100)) d_l5 (.clk(clk), .Reset(Reset), .en(en), .w(w),
                          .clear_count(clear_count), .State(st_l5), .z(z_l5), .match_count(cnt_l5),
                          .count_sat(sat_l5));

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d z=%0d cnt=%0d sat=%0d", o.st, o.z, o.cnt, o.sat);
    endfunction

    function automatic obs_t mk(input int st, input int len, input int cnt, input bit sat);
        obs_t o;
        o.st  = 3'(st);
        o.z   = (st == len);
        o.cnt = 8'(cnt);
        o.sat = sat;
        return o;
    endfunction

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
    task automatic drive(input logic wi, input logic ei, input logic ci);
        w = wi; en = ei; clear_count = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1; en = 1'b0; clear_count = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        logic bits[4] = '{1, 1, 0, 1};
        int   sts[4]  = '{1, 2, 3, 4};
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, 4, 0, 0));
            drive(1'(i), 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_def !== e) begin errors++; $display("FAIL reset_hold[%0d]: got %s want %s", i, fmt(o_def), fmt(e)); end
        end
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(sts[i], 4, (i == 3) ? 1 : 0, 0));
            drive(bits[i], 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_def !== e) begin errors++; $display("FAIL reset_release[%0d]: got %s want %s", i, fmt(o_def), fmt(e)); end
        end
        #2 Reset = 1'b1;
        #1 checks++;
        if (o_def !== '0) begin errors++; $display("FAIL reset_async: got %s want all zero", fmt(o_def)); end
        @(negedge clk);
        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(i, 4, 0, 0));
            drive(1'(i), 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_def !== e) begin errors++; $display("FAIL reset_discard[%0d]: got %s want %s", i, fmt(o_def), fmt(e)); end
        end
    endtask

    task automatic test_overlap();
        obs_t e;
        logic bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        int   sts[7]  = '{1, 2, 3, 4, 2, 3, 4};
        int   cnt = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (sts[i] == 4) cnt++;
            sb.push_back(mk(sts[i], 4, cnt, 0));
            drive(bits[i], 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_def !== e) begin errors++; $display("FAIL overlap[%0d]: got %s want %s", i, fmt(o_def), fmt(e)); end
        end
    endtask

    task automatic test_no_overlap();
        obs_t e;
        logic bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        int   sts[7]  = '{1, 2, 3, 4, 1, 0, 1};
        int   cnt = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (sts[i] == 4) cnt++;
            sb.push_back(mk(sts[i], 4, cnt, 0));
            drive(bits[i], 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_nov !== e) begin errors++; $display("FAIL no_overlap[%0d]: got %s want %s", i, fmt(o_nov), fmt(e)); end
        end
    endtask

    task automatic test_en_gating();
        obs_t e;
        logic bits[7] = '{1, 1, 0, 1, 0, 1, 1};
        logic ens[7]  = '{1, 1, 1, 0, 0, 0, 1};
        int   sts[7]  = '{1, 2, 3, 3, 3, 3, 4};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sb.push_back(mk(sts[i], 4, (sts[i] == 4) ? 1 : 0, 0));
            drive(bits[i], ens[i], 1'b0);
            e = sb.pop_front(); checks++;
            if (o_def !== e) begin errors++; $display("FAIL en_gating[%0d]: got %s want %s", i, fmt(o_def), fmt(e)); end
        end
    endtask

    task automatic test_counter();
        obs_t e;
        logic bits[23];
        logic ens[23];
        logic clrs[23];
        int   sts[23];
        int   cnt = 0;
        for (int i = 0; i < 23; i++) begin
            ens[i]  = 1'b1;
            clrs[i] = 1'b0;
            if (i < 4) begin
                bits[i] = (i != 2);
                sts[i]  = i + 1;
            end else begin
                bits[i] = ((i - 4) % 3 != 1);
                sts[i]  = 2 + (i - 4) % 3;
            end
        end
        clrs[18] = 1'b1;
        ens[22] = 1'b0; clrs[22] = 1'b1; sts[22] = 4;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            if (clrs[i]) cnt = 0;
            else if (ens[i] && sts[i] == 4 && cnt < 3) cnt++;
            sb.push_back(mk(sts[i], 4, cnt, cnt == 3));
            drive(bits[i], ens[i], clrs[i]);
            e = sb.pop_front(); checks++;
            if (o_c2 !== e) begin errors++; $display("FAIL counter[%0d]: got %s want %s", i, fmt(o_c2), fmt(e)); end
        end
        clear_count = 1'b0;
    endtask

    task automatic test_failure_rule();
        obs_t e;
        logic bits[7] = '{1, 0, 1, 0, 1, 0, 0};
        int   sts[7]  = '{1, 2, 3, 4, 3, 4, 5};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sb.push_back(mk(sts[i], 5, (sts[i] == 5) ? 1 : 0, 0));
            drive(bits[i], 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (o_l5 !== e) begin errors++; $display("FAIL failure_rule[%0d]: got %s want %s", i, fmt(o_l5), fmt(e)); end
        end
        en = 1'b0;
        force d_l5.u_state.q = 3'd7;
        #1 release d_l5.u_state.q;
        sb.push_back(mk(0, 5, 1, 0));
        drive(1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (o_l5 !== e) begin errors++; $display("FAIL illegal_recover: got %s want %s", fmt(o_l5), fmt(e)); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_overlap();
        test_no_overlap();
        test_en_gating();
        test_counter();
        test_failure_rule();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
